axi_arbiter: RTL and testbench
==============================

# axi_arbiter

Two-to-one AXI4 arbiter between the core's fetch path (read-only) and load/store path (read + write) and the single `io_master_*` port of the core top. It grants one whole transaction at a time (address phase through last R beat or B response), alternates priority between the two requesters, and routes responses by grant state. It tags outgoing IDs with the fixed per-requester values given in the ID rule under Operation.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `wstrb` is `DATA_W/8`.

Ports (payload fields of a channel share its line; valid/payload direction first, ready direction second):
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `ifu_ar{valid,addr,len,size,burst}` in 1/ADDR_W/8/3/2, `ifu_arready` out 1: fetch read address.
- `ifu_r{valid,data,resp,last}` out 1/DATA_W/2/1, `ifu_rready` in 1: fetch read data.
- `lsu_ar{valid,addr,len,size,burst}` in, `lsu_arready` out: LSU read address, same widths.
- `lsu_r{valid,data,resp,last}` out, `lsu_rready` in: LSU read data.
- `lsu_aw{valid,addr,len,size,burst}` in, `lsu_awready` out: LSU write address.
- `lsu_w{valid,data,strb,last}` in 1/DATA_W/DATA_W/8/1, `lsu_wready` out: LSU write data.
- `lsu_b{valid,resp}` out 1/2, `lsu_bready` in: LSU write response.
- `m_ar{valid,addr,id,len,size,burst}` out 1/ADDR_W/4/8/3/2, `m_arready` in.
- `m_r{valid,data,resp,last}` in, `m_rready` out. Incoming `rid` is ignored.
- `m_aw{valid,addr,id,len,size,burst}` out, `m_awready` in.
- `m_w{valid,data,strb,last}` out, `m_wready` in.
- `m_b{valid,resp}` in, `m_bready` out. Incoming `bid` is ignored.

## Operation
- States: IDLE, RD_IFU, RD_LSU, WR_LSU. A `last_lsu` bit records the most recent grant.
- Grant, evaluated only in IDLE:
  - IFU request: `ifu_arvalid`. LSU request: `lsu_awvalid | lsu_arvalid`.
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not last granted wins.
  - LSU winning with both aw and ar valid: write first (WR_LSU), else RD_LSU.
  - `last_lsu` updates on every grant.
- RD_x:
  - `m_ar*` = selected requester's AR, gated by an `ar_done` flag.
  - `x_arready` = `m_arready & ~ar_done`; `ar_done` sets on the AR handshake.
  - `m_r*` routed to `x_r*`; `m_rready` = `x_rready`.
  - On an R handshake with `rlast=1`: go to IDLE and clear `ar_done`.
- WR_LSU:
  - AW forwarded, gated by `aw_done`.
  - W forwarded and ungated (beats may precede or coincide with AW).
  - B routed to LSU. On the B handshake: go to IDLE and clear `aw_done`.
- Non-granted requester: all readies 0, all response valids 0. Master valids are 0 in IDLE.
- IDs: IFU transactions use `m_arid=0`; LSU reads and writes use id 1.
- `resp` fields pass through unmodified; SLVERR/DECERR end the transaction normally.
- Upstream holds valid and payload stable until handshake, per AXI. The arbiter never withdraws a master valid once asserted.

## Timing
- Reset (async assert): state IDLE, `last_lsu=0` (LSU wins first contention), `ar_done=aw_done=0`.
  - All outputs are 0 during and after reset: valids, readies, payloads.
- Grant latency: a request seen in IDLE at edge k puts the state in RD_x/WR_LSU after k. `m_*valid` asserts in that cycle, 1 cycle after upstream valid.
- Ready and response paths are combinational pass-throughs in the granted state; no buffering.
- Turnaround: after the final R/B handshake at edge k, the state is IDLE for one cycle. The next grant is registered at k+1, giving a minimum of 1 dead cycle between transactions.
- Bursts: any `len` is supported; the transaction ends only on `rlast` or B.
- `rst_i` asserted mid-transaction aborts immediately to IDLE. The outstanding slave transaction is the system's responsibility, since reset is global.

## Test plan
- IFU-only read, len=0, addr 0x8000_0000:
  - `m_arvalid` rises 1 cycle after `ifu_arvalid`, with `m_arid=0`.
  - `rdata` 0x0000_0413 reaches `ifu_rdata`; the state returns to IDLE after `rlast`.
- Simultaneous IFU read and LSU write out of reset:
  - LSU write granted first (`m_awid=1`, `wstrb` 0xF passed through).
  - IFU granted 1 cycle after the B handshake.
- Repeated contention, IFU and LSU reads both held valid for 4 transactions:
  - Grants alternate LSU, IFU, LSU, IFU.
  - `ifu_rvalid` is never asserted during LSU reads.
- LSU burst read, len=3, `m_rvalid` stalled on cycles 2–3:
  - 4 beats delivered in order; grant held until `rlast`.
  - `ifu_arready` stays 0 throughout.
- Slave returns SLVERR (`rresp`=2, `bresp`=2): values appear unchanged at the LSU ports, and arbitration continues.
- `rst_i` pulsed while in RD_LSU after the AR handshake: all outputs go to 0 asynchronously, the state is IDLE, and a new IFU request is granted normally after reset.

Source files
------------

// File: rtl/axi_arbiter.sv
// -----------------------------------------------------------------------------
// axi_arbiter
//   Two-to-one AXI4 arbiter joining the fetch path (IFU, read-only) and the
//   load/store path (LSU, read + write) onto a single AXI4 master port.
//   One whole transaction is granted at a time: from the address phase
//   through the last R beat or the B response. Priority alternates between
//   the two requesters on contention. Responses are routed back by grant
//   state, and outgoing IDs are fixed per requester (IFU = 0, LSU = 1).
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   ifu_ar*  / ifu_r*     fetch read address / read data
//   lsu_ar*  / lsu_r*     LSU read address / read data
//   lsu_aw*  / lsu_w*     LSU write address / write data
//   lsu_b*                LSU write response
//   m_ar* m_r* m_aw* m_w* m_b*   shared master port (rid/bid not used)
// -----------------------------------------------------------------------------
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // IFU read address
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic [1:0]          ifu_arburst,
  output logic                ifu_arready,
  // IFU read data
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  input  logic                ifu_rready,
  // LSU read address
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic [1:0]          lsu_arburst,
  output logic                lsu_arready,
  // LSU read data
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  input  logic                lsu_rready,
  // LSU write address
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [1:0]          lsu_awburst,
  output logic                lsu_awready,
  // LSU write data
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  output logic                lsu_wready,
  // LSU write response
  output logic                lsu_bvalid,
  output logic [1:0]          lsu_bresp,
  input  logic                lsu_bready,
  // Master read address
  output logic                m_arvalid,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [3:0]          m_arid,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  input  logic                m_arready,
  // Master read data
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  output logic                m_rready,
  // Master write address
  output logic                m_awvalid,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [3:0]          m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  input  logic                m_awready,
  // Master write data
  output logic                m_wvalid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_wready,
  // Master write response
  input  logic                m_bvalid,
  input  logic [1:0]          m_bresp,
  output logic                m_bready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } state_t;

  localparam logic [3:0] IFU_ID = 4'd0;
  localparam logic [3:0] LSU_ID = 4'd1;

  state_t r_state;
  state_t w_next_state;
  logic   r_last_lsu;   // 1 when the most recent grant went to the LSU
  logic   r_ar_done;    // AR handshake already taken for this read
  logic   r_aw_done;    // AW handshake already taken for this write
  logic   w_last_lsu_nxt;
  logic   w_ar_done_nxt;
  logic   w_aw_done_nxt;

  logic   w_ifu_req;
  logic   w_lsu_req;

  assign w_ifu_req = ifu_arvalid;
  assign w_lsu_req = lsu_awvalid | lsu_arvalid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_last_lsu <= 1'b0;
      r_ar_done  <= 1'b0;
      r_aw_done  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_last_lsu <= w_last_lsu_nxt;
      r_ar_done  <= w_ar_done_nxt;
      r_aw_done  <= w_aw_done_nxt;
    end
  end

  // All outputs decode purely from r_state, so an asynchronous reset drives
  // every output to 0 in the same instant the state register clears.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_next_state   = r_state;
    w_last_lsu_nxt = r_last_lsu;
    w_ar_done_nxt  = r_ar_done;
    w_aw_done_nxt  = r_aw_done;

    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rlast   = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rlast   = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = 2'b00;

    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arid    = 4'd0;
    m_arlen   = 8'd0;
    m_arsize  = 3'd0;
    m_arburst = 2'd0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awid    = 4'd0;
    m_awlen   = 8'd0;
    m_awsize  = 3'd0;
    m_awburst = 2'd0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;

    unique case (r_state)
      IDLE: begin
        // On contention the side not granted last time wins; r_last_lsu=0
        // out of reset therefore favours the LSU first.
        if (w_ifu_req && (!w_lsu_req || r_last_lsu)) begin
          w_next_state   = RD_IFU;
          w_last_lsu_nxt = 1'b0;
        end else if (w_lsu_req) begin
          // A pending write goes ahead of a pending LSU read.
          w_next_state   = lsu_awvalid ? WR_LSU : RD_LSU;
          w_last_lsu_nxt = 1'b1;
        end
      end

      RD_IFU: begin
        m_arvalid   = ifu_arvalid & ~r_ar_done;
        m_araddr    = ifu_araddr;
        m_arid      = IFU_ID;
        m_arlen     = ifu_arlen;
        m_arsize    = ifu_arsize;
        m_arburst   = ifu_arburst;
        ifu_arready = m_arready & ~r_ar_done;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rlast   = m_rlast;
        m_rready    = ifu_rready;
        if (m_arvalid && m_arready) begin
          w_ar_done_nxt = 1'b1;
        end
        if (m_rvalid && ifu_rready && m_rlast) begin
          w_next_state  = IDLE;
          w_ar_done_nxt = 1'b0;
        end
      end

      RD_LSU: begin
        m_arvalid   = lsu_arvalid & ~r_ar_done;
        m_araddr    = lsu_araddr;
        m_arid      = LSU_ID;
        m_arlen     = lsu_arlen;
        m_arsize    = lsu_arsize;
        m_arburst   = lsu_arburst;
        lsu_arready = m_arready & ~r_ar_done;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rlast   = m_rlast;
        m_rready    = lsu_rready;
        if (m_arvalid && m_arready) begin
          w_ar_done_nxt = 1'b1;
        end
        if (m_rvalid && lsu_rready && m_rlast) begin
          w_next_state  = IDLE;
          w_ar_done_nxt = 1'b0;
        end
      end

      WR_LSU: begin
        m_awvalid   = lsu_awvalid & ~r_aw_done;
        m_awaddr    = lsu_awaddr;
        m_awid      = LSU_ID;
        m_awlen     = lsu_awlen;
        m_awsize    = lsu_awsize;
        m_awburst   = lsu_awburst;
        lsu_awready = m_awready & ~r_aw_done;
        // W is not gated by aw_done: data beats may lead or coincide with AW.
        m_wvalid    = lsu_wvalid;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wlast     = lsu_wlast;
        lsu_wready  = m_wready;
        lsu_bvalid  = m_bvalid;
        lsu_bresp   = m_bresp;
        m_bready    = lsu_bready;
        if (m_awvalid && m_awready) begin
          w_aw_done_nxt = 1'b1;
        end
        if (m_bvalid && lsu_bready) begin
          w_next_state  = IDLE;
          w_aw_done_nxt = 1'b0;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_arbiter
//   Self-checking bench for axi_arbiter. The bench plays both upstream
//   requesters and the downstream slave. A table of contention vectors walks
//   the grant sequence (expected winners computed by hand from the alternating
//   priority rule); hand-written sequences cover the single IFU read, a
//   stalled LSU burst and a reset pulse in the middle of a read.
// -----------------------------------------------------------------------------
module tb_axi_arbiter;

  localparam int A = 32;
  localparam int D = 32;

  localparam logic [31:0] IFU_ADDR = 32'h8000_0000;
  localparam logic [31:0] LSU_RADDR = 32'h2000_0010;
  localparam logic [31:0] LSU_WADDR = 32'h2000_0020;

  logic clk_i, rst_i;
  logic ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
  logic [A-1:0] ifu_araddr;
  logic [7:0] ifu_arlen;
  logic [2:0] ifu_arsize;
  logic [1:0] ifu_arburst, ifu_rresp;
  logic [D-1:0] ifu_rdata;
  logic lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
  logic [A-1:0] lsu_araddr, lsu_awaddr;
  logic [7:0] lsu_arlen, lsu_awlen;
  logic [2:0] lsu_arsize, lsu_awsize;
  logic [1:0] lsu_arburst, lsu_awburst, lsu_rresp, lsu_bresp;
  logic [D-1:0] lsu_rdata, lsu_wdata;
  logic lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
  logic [D/8-1:0] lsu_wstrb, m_wstrb;
  logic lsu_bvalid, lsu_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [A-1:0] m_araddr, m_awaddr;
  logic [3:0] m_arid, m_awid;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize;
  logic [1:0] m_arburst, m_awburst, m_rresp, m_bresp;
  logic [D-1:0] m_rdata, m_wdata;
  logic m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic m_bvalid, m_bready;

  int n_chk = 0;
  int n_err = 0;

  axi_arbiter #(.ADDR_W(A), .DATA_W(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Contention vector: requests present at grant time and the expected
  // winner encoded as {m_awvalid, m_arvalid, m_arid[0]}.
  typedef struct {
    logic        ifu;
    logic        lar;
    logic        law;
    logic [2:0]  exp;
    logic [1:0]  resp;
    logic [31:0] data;
    int          beats;
  } vec_t;

  localparam logic [2:0] G_IFU = 3'b010;
  localparam logic [2:0] G_LRD = 3'b011;
  localparam logic [2:0] G_WR  = 3'b100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  function automatic logic any_out();
    return |{ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, ifu_rlast,
             lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_rlast,
             lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
             m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready,
             m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst,
             m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready};
  endfunction

  task automatic clear_inputs();
    ifu_arvalid = 0; ifu_araddr = IFU_ADDR; ifu_arlen = 0; ifu_arsize = 3'd2; ifu_arburst = 2'd1;
    lsu_arvalid = 0; lsu_araddr = LSU_RADDR; lsu_arlen = 0; lsu_arsize = 3'd2; lsu_arburst = 2'd1;
    lsu_awvalid = 0; lsu_awaddr = LSU_WADDR; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awburst = 2'd1;
    lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    clear_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Wait for either master valid; returns the number of edges taken.
  task automatic wait_grant(input string name, output int cyc);
    cyc = 0;
    sample();
    while (!(m_arvalid || m_awvalid)) begin
      step();
      cyc++;
      if (cyc > 20) begin
        check({name, "_timeout"}, 64'd0, 64'd1);
        return;
      end
      sample();
    end
  endtask

  // Read transaction, entered at the negedge where m_arvalid is high.
  // Bursts may stall for stall_n cycles starting at cycle stall_at.
  task automatic rd_txn(input bit lsu, input logic [31:0] base, input logic [1:0] resp,
                        input int stall_at, input int stall_n);
    int nb, b, cyc;
    logic [31:0] addr;
    logic xv, xl, ov, xar;
    logic [31:0] xd;
    logic [1:0] xr;
    nb   = lsu ? int'(lsu_arlen) + 1 : int'(ifu_arlen) + 1;
    addr = lsu ? LSU_RADDR : IFU_ADDR;
    check("arid", m_arid, {3'b0, lsu});
    check("araddr", m_araddr, addr);
    check("arlen", m_arlen, nb - 1);
    check("arsize_burst", {m_arsize, m_arburst}, {3'd2, 2'd1});
    m_arready = 1'b1;
    #1;
    check("arready_fwd", lsu ? lsu_arready : ifu_arready, 1'b1);
    check("other_arready", lsu ? ifu_arready : lsu_arready, 1'b0);
    step();
    m_arready = 1'b0;
    b = 0;
    cyc = 0;
    while (b < nb) begin
      if (cyc >= stall_at && cyc < stall_at + stall_n) begin
        m_rvalid = 1'b0;
        sample();
        check("stall_rvalid", lsu ? lsu_rvalid : ifu_rvalid, 1'b0);
        if (lsu) check("ifu_arready_burst", ifu_arready, 1'b0);
      end else begin
        m_rvalid = 1'b1;
        m_rdata  = base + b;
        m_rresp  = resp;
        m_rlast  = (b == nb - 1);
        sample();
        xv = lsu ? lsu_rvalid : ifu_rvalid;
        xd = lsu ? lsu_rdata  : ifu_rdata;
        xr = lsu ? lsu_rresp  : ifu_rresp;
        xl = lsu ? lsu_rlast  : ifu_rlast;
        ov = lsu ? ifu_rvalid : lsu_rvalid;
        check("rvalid", xv, 1'b1);
        check("rdata", xd, base + b);
        check("rresp", xr, resp);
        check("rlast", xl, m_rlast);
        check("other_rvalid", ov, 1'b0);
        check("rready", m_rready, 1'b1);
        if (lsu) check("ifu_arready_burst", ifu_arready, 1'b0);
        b++;
      end
      if (cyc == 0) begin
        // Upstream arvalid still high here: the AR must already be retired.
        xar = lsu ? lsu_arready : ifu_arready;
        check("ar_done_gate", {m_arvalid, xar}, 2'b00);
        if (lsu) lsu_arvalid = 1'b0; else ifu_arvalid = 1'b0;
      end
      step();
      cyc++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  // Write transaction, entered at the negedge where m_awvalid is high.
  task automatic wr_txn(input logic [31:0] data, input logic [1:0] resp);
    check("awid", m_awid, 4'd1);
    check("awaddr", m_awaddr, LSU_WADDR);
    check("wr_no_ar", m_arvalid, 1'b0);
    check("wvalid", m_wvalid, 1'b1);
    check("wdata", m_wdata, data);
    check("wstrb", m_wstrb, 4'hF);
    check("wlast", m_wlast, 1'b1);
    m_awready = 1'b1;
    m_wready  = 1'b1;
    #1;
    check("aw_w_ready", {lsu_awready, lsu_wready, lsu_arready}, 3'b110);
    step();
    m_awready  = 1'b0;
    m_wready   = 1'b0;
    lsu_wvalid = 1'b0;
    m_bvalid   = 1'b1;
    m_bresp    = resp;
    sample();
    check("aw_done_gate", {m_awvalid, lsu_awready}, 2'b00);
    check("bvalid", lsu_bvalid, 1'b1);
    check("bresp", lsu_bresp, resp);
    check("bready", m_bready, 1'b1);
    check("wr_ifu_rvalid", ifu_rvalid, 1'b0);
    step();
    lsu_awvalid = 1'b0;
    m_bvalid    = 1'b0;
  endtask

  vec_t vt[10];
  int cyc;

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b1, G_WR,  2'd0, 32'hA000_0000, 1};
    vt[1] = '{1'b1, 1'b0, 1'b0, G_IFU, 2'd0, 32'h0000_0413, 1};
    vt[2] = '{1'b1, 1'b1, 1'b0, G_LRD, 2'd0, 32'hB000_0000, 2};
    vt[3] = '{1'b1, 1'b1, 1'b0, G_IFU, 2'd0, 32'hC000_0000, 1};
    vt[4] = '{1'b1, 1'b1, 1'b0, G_LRD, 2'd0, 32'hD000_0000, 1};
    vt[5] = '{1'b1, 1'b0, 1'b0, G_IFU, 2'd0, 32'hE000_0000, 1};
    vt[6] = '{1'b0, 1'b1, 1'b1, G_WR,  2'd2, 32'h5A5A_5A5A, 1};
    vt[7] = '{1'b1, 1'b1, 1'b0, G_IFU, 2'd0, 32'h1234_0000, 1};
    vt[8] = '{1'b0, 1'b1, 1'b0, G_LRD, 2'd2, 32'h4321_0000, 2};
    vt[9] = '{1'b0, 1'b0, 1'b1, G_WR,  2'd2, 32'h0F0F_0F0F, 1};

    // Reset with requests and slave responses active: outputs must stay 0.
    rst_i = 1'b1;
    clear_inputs();
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; m_rvalid = 1'b1; m_bvalid = 1'b1;
    m_rdata = 32'hFFFF_FFFF; m_arready = 1'b1;
    #2;
    check("in_reset_zero", any_out(), 1'b0);
    clear_inputs();
    step();
    step();
    rst_i = 1'b0;
    sample();
    check("post_reset_zero", any_out(), 1'b0);

    // IFU-only single read.
    step();
    ifu_arvalid = 1'b1;
    ifu_arlen   = 8'd0;
    wait_grant("ifu_only", cyc);
    check("ifu_only_latency", cyc, 1);
    rd_txn(1'b0, 32'h0000_0413, 2'd0, -1, 0);
    sample();
    check("idle_after_rlast", {m_arvalid, m_awvalid, ifu_arready, ifu_rvalid}, 4'b0000);

    // Contention table from a fresh reset (LSU wins first contention).
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (vt[i].ifu && !ifu_arvalid) ifu_arlen = 8'(vt[i].beats - 1);
      if (vt[i].lar && !lsu_arvalid) lsu_arlen = 8'(vt[i].beats - 1);
      if (vt[i].law && !lsu_awvalid) begin
        lsu_wvalid = 1'b1;
        lsu_wdata  = vt[i].data;
        lsu_wstrb  = 4'hF;
        lsu_wlast  = 1'b1;
      end
      ifu_arvalid = vt[i].ifu;
      lsu_arvalid = vt[i].lar;
      lsu_awvalid = vt[i].law;
      wait_grant($sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d_latency", i), cyc, 1);
      check($sformatf("vec%0d_grant", i), {m_awvalid, m_arvalid, m_arid[0]}, vt[i].exp);
      if (vt[i].exp == G_WR) wr_txn(vt[i].data, vt[i].resp);
      else rd_txn(vt[i].exp == G_LRD, vt[i].data, vt[i].resp, -1, 0);
    end

    // LSU len=3 burst stalled on cycles 2-3 while the IFU waits.
    do_reset();
    ifu_arvalid = 1'b1;
    lsu_arvalid = 1'b1;
    lsu_arlen   = 8'd3;
    wait_grant("burst", cyc);
    check("burst_grant", {m_awvalid, m_arvalid, m_arid[0]}, G_LRD);
    rd_txn(1'b1, 32'h0000_1000, 2'd0, 2, 2);
    wait_grant("burst_ifu", cyc);
    check("burst_ifu_latency", cyc, 1);
    check("burst_ifu_grant", {m_awvalid, m_arvalid, m_arid[0]}, G_IFU);
    rd_txn(1'b0, 32'h0000_2000, 2'd0, -1, 0);

    // Reset pulse in RD_LSU after the AR handshake.
    do_reset();
    lsu_arvalid = 1'b1;
    lsu_arlen   = 8'd1;
    wait_grant("rst_mid", cyc);
    m_arready = 1'b1;
    step();
    m_arready   = 1'b0;
    lsu_arvalid = 1'b0;
    ifu_arvalid = 1'b1;
    m_rvalid    = 1'b1;
    m_rdata     = 32'hCAFE_F00D;
    m_rlast     = 1'b0;
    sample();
    check("rst_mid_rvalid_before", lsu_rvalid, 1'b1);
    rst_i = 1'b1;
    #1;
    check("rst_mid_async_zero", any_out(), 1'b0);
    step();
    m_rvalid = 1'b0;
    step();
    rst_i = 1'b0;
    wait_grant("rst_mid_ifu", cyc);
    check("rst_mid_ifu_latency", cyc, 1);
    check("rst_mid_ifu_grant", {m_awvalid, m_arvalid, m_arid[0]}, G_IFU);
    rd_txn(1'b0, 32'h0000_3000, 2'd0, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
